// File: rtl/frame_pkg.sv
// Shared definitions for the frame sequencer: state encoding, CRC-8 constants
// and default frame/watchdog sizing.
package frame_pkg;

    localparam int FRAME_LEN_DEF   = 16;
    localparam int TIMEOUT_CYC_DEF = 5000000;

    // CRC-8 as implemented by the external engine (non-reflected, no final xor)
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_CLR      = 4'd1;
    localparam state_t ST_WAIT_RX  = 4'd2;
    localparam state_t ST_ISSUE    = 4'd3;
    localparam state_t ST_WAIT_HI  = 4'd4;
    localparam state_t ST_WAIT_LO  = 4'd5;
    localparam state_t ST_CRC_SEND = 4'd6;
    localparam state_t ST_CRC_HI   = 4'd7;
    localparam state_t ST_CRC_LO   = 4'd8;
    localparam state_t ST_DONE     = 4'd9;

    // States in which the sequencer is blocked on an external party
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WAIT_RX) || (s == ST_WAIT_HI) || (s == ST_WAIT_LO) ||
               (s == ST_CRC_HI)  || (s == ST_CRC_LO);
    endfunction

endpackage

// File: rtl/frame_tx_ctrl_busy_handshake.sv
// Two-phase sender handshake tracker: first sees tx_busy rise, then fall.
// Shared by the payload (WAIT_HI/WAIT_LO) and trailer (CRC_HI/CRC_LO) paths.
module busy_handshake (
    input  logic track_hi,
    input  logic track_lo,
    input  logic tx_busy,
    output logic seen_rise,
    output logic seen_fall
);

    assign seen_rise = track_hi &  tx_busy;
    assign seen_fall = track_lo & ~tx_busy;

endmodule

// File: rtl/frame_tx_ctrl.sv
// Frame sequencer: forwards FRAME_LEN UART bytes to the inter-FPGA sender and
// appends the CRC-8 trailer. Define FRAME_TX_CTRL_TIMEOUT_EN for the watchdog.
module frame_tx_ctrl
    import frame_pkg::*;
#(
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_clear,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic       crc_clr,
    output logic       crc_en,
    input  logic [7:0] crc_in,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic [7:0] byte_count
);

    state_t     state;
    state_t     state_next;
    logic [7:0] tx_data_q;
    logic       seen_rise;
    logic       seen_fall;
    logic       timeout_hit;
    logic       more_bytes;

    busy_handshake u_handshake (
        .track_hi  ((state == ST_WAIT_HI) || (state == ST_CRC_HI)),
        .track_lo  ((state == ST_WAIT_LO) || (state == ST_CRC_LO)),
        .tx_busy   (tx_busy),
        .seen_rise (seen_rise),
        .seen_fall (seen_fall)
    );

    assign more_bytes = byte_count < 8'(FRAME_LEN);

`ifdef FRAME_TX_CTRL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt;

    assign timeout_hit = is_wait_state(state) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state_next != state) begin
            wd_cnt <= '0;
        end else if (is_wait_state(state)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    // Without the watchdog the timeout length has no effect
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        // NOTE: default first so every path assigns state_next (no latch)
        state_next = state;
        case (state)
            ST_IDLE:     if (start)     state_next = ST_CLR;
            ST_CLR:                     state_next = ST_WAIT_RX;
            ST_WAIT_RX:  if (rx_ready)  state_next = ST_ISSUE;
            ST_ISSUE:                   state_next = ST_WAIT_HI;
            ST_WAIT_HI:  if (seen_rise) state_next = ST_WAIT_LO;
            ST_WAIT_LO:  if (seen_fall) state_next = more_bytes ? ST_WAIT_RX : ST_CRC_SEND;
            ST_CRC_SEND:                state_next = ST_CRC_HI;
            ST_CRC_HI:   if (seen_rise) state_next = ST_CRC_LO;
            ST_CRC_LO:   if (seen_fall) state_next = ST_DONE;
            ST_DONE:                    state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_next = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tx_data_q  <= 8'h00;
            byte_count <= 8'h00;
        end else begin
            state <= state_next;
            if (state_next == ST_ISSUE) begin
                tx_data_q <= rx_data;
            end else if (state == ST_CRC_SEND) begin
                tx_data_q <= crc_in;
            end
            // byte_count survives IDLE and aborts; only CLR restarts it
            if (state == ST_CLR) begin
                byte_count <= 8'h00;
            end else if (state == ST_ISSUE) begin
                byte_count <= byte_count + 8'd1;
            end
        end
    end

    // Trailer byte is taken straight from the engine while CRC_SEND is active
    assign tx_data = (state == ST_CRC_SEND) ? crc_in : tx_data_q;

    // Strobes are masked while reset is held so none leaks out of a reset cycle
    assign tx_send     = ~reset & ((state == ST_ISSUE) || (state == ST_CRC_SEND));
    assign crc_en      = ~reset & (state == ST_ISSUE);
    assign rx_clear    = ~reset & (state == ST_ISSUE);
    assign crc_clr     = ~reset & (state == ST_CLR);
    assign done        = ~reset & (state == ST_DONE);
    assign err_timeout = ~reset & timeout_hit;
    assign busy        = ~reset & (state != ST_IDLE);

endmodule

// File: tb/tb_frame_tx_ctrl.sv
// Self-checking bench for frame_tx_ctrl with behavioural receiver, sender and
// CRC-8 engine; timeout checks depend on FRAME_TX_CTRL_TIMEOUT_EN.
module tb_frame_tx_ctrl;
    import frame_pkg::*;

    localparam int FL = 4;
    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_clear;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc_in;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [7:0] byte_count;

    frame_tx_ctrl #(.FRAME_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_clear    (rx_clear),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_busy     (tx_busy),
        .crc_clr     (crc_clr),
        .crc_en      (crc_en),
        .crc_in      (crc_in),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] outs;
    assign outs = {9'd0, rx_clear, tx_data, tx_send, crc_clr, crc_en, busy, done, err_timeout, byte_count};

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ CRC8_POLY) : (r << 1);
        return r;
    endfunction

    // CRC engine
    logic [7:0] crc_q = 8'h00;
    assign crc_in = crc_q;
    always @(posedge clk) begin
        if (crc_clr)     crc_q <= CRC8_INIT;
        else if (crc_en) crc_q <= crc8_byte(crc_q, tx_data);
    end

    // Sender: busy for busy_len cycles (0 selects a random 1..8) after each launch
    int busy_len  = 10;
    int busy_left = 0;
    int rnd_len   = 1;
    int busy_q[$];
    always @(posedge clk) begin
        rnd_len <= int'($urandom_range(8, 1));
        if (tx_send) begin
            busy_left <= (busy_len != 0) ? busy_len : rnd_len;
            busy_q.push_back((busy_len != 0) ? busy_len : rnd_len);
        end else if (busy_left != 0) begin
            busy_left <= busy_left - 1;
        end
    end
    assign tx_busy = (busy_left != 0);

    // Receiver: presents queued bytes; rx_gap idle cycles after each clear
    logic [7:0] rx_q[$];
    int rx_gap   = 0;
    int gap_left = 0;
    bit rx_flush = 1'b0;
    always @(posedge clk) begin
        if (rx_flush) begin
            rx_ready <= 1'b0;
            rx_q.delete();
            gap_left <= 0;
        end else if (rx_clear) begin
            if (rx_gap == 0 && rx_q.size() != 0) begin
                rx_data <= rx_q.pop_front();
            end else begin
                rx_ready <= 1'b0;
                gap_left <= rx_gap;
            end
        end else if (!rx_ready) begin
            if (gap_left != 0)          gap_left <= gap_left - 1;
            else if (rx_q.size() != 0) begin
                rx_data  <= rx_q.pop_front();
                rx_ready <= 1'b1;
            end
        end
    end

    // Event log
    logic [7:0] send_dat[$];
    int send_cyc[$];
    int n_rxclr = 0, n_crcclr = 0, n_done = 0, n_err = 0;
    always @(negedge clk) begin
        if (tx_send) begin
            send_dat.push_back(tx_data);
            send_cyc.push_back(cyc);
        end
        if (rx_clear)    n_rxclr  <= n_rxclr + 1;
        if (crc_clr)     n_crcclr <= n_crcclr + 1;
        if (done)        n_done   <= n_done + 1;
        if (err_timeout) n_err    <= n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge
    task automatic pulse_start(output int s);
        start = 1'b1;
        s     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output int e);
        e = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done || err_timeout) begin
                e = cyc;
                break;
            end
        end
    endtask

    task automatic wait_sends(input int n, input int limit, output int got);
        got = 0;
        for (int i = 0; i < limit && got < n; i++) begin
            @(negedge clk);
            if (tx_send) got++;
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] pay[$]);
        logic [7:0] exp[$];
        logic [7:0] c;
        c   = CRC8_INIT;
        exp = pay;
        foreach (pay[i]) c = crc8_byte(c, pay[i]);
        exp.push_back(c);
        check({tag, "_send_count"}, send_dat.size() - base, exp.size());
        foreach (exp[i])
            check({tag, "_byte"}, (base + i < send_dat.size()) ? {24'd0, send_dat[base + i]} : 32'hxxxx_xxxx, exp[i]);
    endtask

    task automatic load(input logic [7:0] pay[$]);
        foreach (pay[i]) rx_q.push_back(pay[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: observed no finish, expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int s, e, base, bq0, r0, c0, d0, e0, k;
        logic [7:0] pay[$];

        // Reset held 3 cycles, then one idle cycle
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", outs, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", outs, 32'd0);

        // Frame 1: 01..04, sender busy 10, rx_ready continuous
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        load(pay);
        busy_len = 10; rx_gap = 0;
        base = send_dat.size(); r0 = n_rxclr; c0 = n_crcclr; d0 = n_done; e0 = n_err;
        pulse_start(s);
        check("f1_crc_clr", crc_clr, 1);
        check("f1_busy_in_clr", busy, 1);
        wait_end(400, e);
        check("f1_done_seen", done, 1);
        @(negedge clk);
        check("f1_busy_after_done", busy, 0);
        check_frame("f1", base, pay);
        check("f1_trailer_e3", send_dat[base + 4], 8'hE3);
        check("f1_first_issue", send_cyc[base], s + 3);
        for (int i = 1; i < FL; i++)
            check("f1_byte_interval", send_cyc[base + i] - send_cyc[base + i - 1], busy_len + 3);
        check("f1_trailer_interval", send_cyc[base + FL] - send_cyc[base + FL - 1], busy_len + 2);
        check("f1_done_cycle", e, send_cyc[base + FL] + busy_len + 2);
        check("f1_rx_clear_count", n_rxclr - r0, FL);
        check("f1_crc_clr_count", n_crcclr - c0, 1);
        check("f1_done_count", n_done - d0, 1);
        check("f1_err_count", n_err - e0, 0);
        check("f1_byte_count", byte_count, FL);

        // Frame 2: started the cycle after done; a second start mid-frame is ignored
        pay = {};
        for (int i = 0; i < FL; i++) pay.push_back(8'($urandom));
        load(pay);
        busy_len = 0; rx_gap = 0;
        base = send_dat.size(); bq0 = busy_q.size(); c0 = n_crcclr; d0 = n_done;
        pulse_start(s);
        check("f2_restart_crc_clr", crc_clr, 1);
        wait_sends(1, 100, k);
        check("f2_first_send_seen", k, 1);
        pulse_start(k);
        check("f2_midframe_no_clr", crc_clr, 0);
        check("f2_midframe_busy", busy, 1);
        wait_end(400, e);
        @(negedge clk);
        check_frame("f2", base, pay);
        for (int i = 1; i < FL; i++)
            check("f2_byte_interval", send_cyc[base + i] - send_cyc[base + i - 1], busy_q[bq0 + i - 1] + 3);
        check("f2_done_cycle", e, send_cyc[base + FL] + busy_q[bq0 + FL] + 2);
        check("f2_crc_clr_count", n_crcclr - c0, 1);
        check("f2_done_count", n_done - d0, 1);
        check("f2_byte_count", byte_count, FL);

        // Randomized frames with receiver gaps and random sender busy time
        for (int f = 0; f < 4; f++) begin
            pay = {};
            for (int i = 0; i < FL; i++) pay.push_back(8'($urandom));
            load(pay);
            rx_gap = int'($urandom_range(4, 0));
            base = send_dat.size(); d0 = n_done; e0 = n_err;
            pulse_start(s);
            wait_end(400, e);
            @(negedge clk);
            check_frame("rand", base, pay);
            check("rand_done_count", n_done - d0, 1);
            check("rand_err_count", n_err - e0, 0);
            check("rand_byte_count", byte_count, FL);
        end

        // Reset mid-frame after two bytes
        pay = {};
        for (int i = 0; i < FL; i++) pay.push_back(8'($urandom));
        load(pay);
        busy_len = 3; rx_gap = 0;
        pulse_start(s);
        wait_sends(2, 200, k);
        check("mr_two_sends_seen", k, 2);
        reset = 1'b1; rx_flush = 1'b1;
        #1;
        check("mr_no_strobe_in_reset", {tx_send, crc_en, rx_clear, crc_clr, done, err_timeout}, 0);
        @(negedge clk);
        check("mr_outputs_after_reset", outs, 32'd0);
        reset = 1'b0; rx_flush = 1'b0;
        base = send_dat.size();
        repeat (20) @(negedge clk);
        check("mr_no_further_send", send_dat.size() - base, 0);
        check("mr_still_idle", busy, 0);

        // Frame after reset still produces the 0xE3 trailer
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        load(pay);
        busy_len = 10;
        base = send_dat.size();
        pulse_start(s);
        wait_end(400, e);
        @(negedge clk);
        check_frame("mr_next", base, pay);
        check("mr_next_trailer_e3", send_dat[base + 4], 8'hE3);

`ifdef FRAME_TX_CTRL_TIMEOUT_EN
        // No receiver data at all: abort after TO cycles in WAIT_RX
        d0 = n_done; e0 = n_err;
        pulse_start(s);
        wait_end(400, e);
        check("to_rx_err_seen", err_timeout, 1);
        check("to_rx_no_done", done, 0);
        check("to_rx_cycle", e, s + 2 + TO - 1);
        @(negedge clk);
        check("to_rx_busy_low", busy, 0);
        check("to_rx_err_one_cycle", err_timeout, 0);

        // Two bytes then silence: byte_count kept for debug
        pay = '{8'($urandom), 8'($urandom)};
        load(pay);
        busy_len = 3;
        base = send_dat.size();
        pulse_start(s);
        wait_end(400, e);
        check("to_mid_err_seen", err_timeout, 1);
        check("to_mid_cycle", e, send_cyc[base + 1] + busy_len + 2 + TO - 1);
        @(negedge clk);
        check("to_mid_busy_low", busy, 0);
        check("to_mid_byte_count", byte_count, 2);
        check("to_mid_send_count", send_dat.size() - base, 2);
        check("to_done_count", n_done - d0, 0);
        check("to_err_count", n_err - e0, 2);
`else
        // Without the watchdog a stalled frame waits indefinitely, then completes
        pay = '{8'($urandom), 8'($urandom)};
        load(pay);
        busy_len = 3;
        base = send_dat.size(); d0 = n_done; e0 = n_err;
        pulse_start(s);
        repeat (3 * TO) @(negedge clk);
        check("nowd_no_err", n_err - e0, 0);
        check("nowd_still_busy", busy, 1);
        check("nowd_byte_count", byte_count, 2);
        pay.push_back(8'($urandom));
        pay.push_back(8'($urandom));
        rx_q.push_back(pay[2]);
        rx_q.push_back(pay[3]);
        wait_end(400, e);
        @(negedge clk);
        check_frame("nowd", base, pay);
        check("nowd_done_count", n_done - d0, 1);
        check("nowd_err_final", n_err - e0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
